// File: rtl/divider32b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider32b_pkg
//  Description : Shared constants for the 32-bit sequential divider.
//                Holds the FSM encoding, the data width and iteration count,
//                the divide-by-zero quotient and the small helpers used for
//                the optional two's-complement mode (DIVIDER32B_SIGNED_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
package divider32b_pkg;

    localparam int C_WIDTH = 32;
    localparam int C_ITERS = 32;
    localparam int C_CNT_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [C_WIDTH-1:0] C_DBZ_QUOT = 32'hFFFF_FFFF;

    // Two's-complement negate, used to build magnitudes and to apply the
    // result signs. -2^31 maps to itself, which reads correctly as the
    // unsigned magnitude 2^31.
    function automatic logic [C_WIDTH-1:0] neg_if(input logic [C_WIDTH-1:0] v,
                                                  input logic              en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage : divider32b_pkg
`default_nettype wire

// File: rtl/divider32b_subtractor32b.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor32b
//  Description : Combinational 32-bit subtractor, o_diff = i_a - i_b, with
//                o_borrow set when i_b > i_a (unsigned).
//  Ports       : i_a, i_b  - operands
//                o_diff    - difference modulo 2^32
//                o_borrow  - borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
module subtractor32b
    import divider32b_pkg::*;
(
    input  logic [C_WIDTH-1:0] i_a,
    input  logic [C_WIDTH-1:0] i_b,
    output logic [C_WIDTH-1:0] o_diff,
    output logic               o_borrow
);

    assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule : subtractor32b
`default_nettype wire

// File: rtl/divider32b.sv
`default_nettype none
// ============================================================================
//  Module      : divider32b
//  Description : Sequential restoring divider, 32-bit dividend / divisor,
//                one quotient bit per clock, MSB first. Accept-to-done
//                latency is 32 cycles; a zero divisor finishes on the accept
//                edge with quotient all-ones and remainder = dividend.
//  Ports       : wb_clk_i, wb_rst_i (sync, active-high)
//                start, dividend, divisor     - request (sampled in IDLE)
//                signed_op                    - only with DIVIDER32B_SIGNED_EN
//                busy, done                   - status (done is a 1-cycle pulse)
//                quotient, remainder          - results, held until next start
//                div_by_zero                  - last result had divisor 0
//                io_oeb                       - tied low
//  Macro       : DIVIDER32B_SIGNED_EN adds signed_op (two's-complement mode)
//  Revision    : 1.0 - initial release
// ============================================================================
module divider32b
    import divider32b_pkg::*;
(
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start,
    input  logic [C_WIDTH-1:0] dividend,
    input  logic [C_WIDTH-1:0] divisor,
`ifdef DIVIDER32B_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [C_WIDTH-1:0] quotient,
    output logic [C_WIDTH-1:0] remainder,
    output logic               div_by_zero,
    output logic [32:0]        io_oeb
);

    logic [1:0]         r_state;
    logic [C_WIDTH:0]   r_prem;      // partial remainder, 33 bits
    logic [C_WIDTH-1:0] r_qsh;       // dividend bits shift out, quotient bits shift in
    logic [C_WIDTH-1:0] r_dvsr;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_WIDTH-1:0] r_quotient;
    logic [C_WIDTH-1:0] r_remainder;
    logic               r_dbz;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_signed;
    logic [C_WIDTH-1:0] w_dvd_mag;
    logic [C_WIDTH-1:0] w_dvs_mag;
    logic               w_dvs_zero;
    logic [C_WIDTH+1:0] w_shift;
    logic [C_WIDTH-1:0] w_diff;
    logic               w_borrow;
    logic               w_ge;
    logic [C_WIDTH:0]   w_prem_next;
    logic [C_WIDTH-1:0] w_q_next;
    logic [C_WIDTH-1:0] w_q_final;
    logic [C_WIDTH-1:0] w_r_final;
    logic               w_last;

`ifdef DIVIDER32B_SIGNED_EN
    assign w_signed = signed_op;
`else
    assign w_signed = 1'b0;
`endif

    assign w_dvd_mag  = neg_if(dividend, w_signed & dividend[C_WIDTH-1]);
    assign w_dvs_mag  = neg_if(divisor,  w_signed & divisor[C_WIDTH-1]);
    assign w_dvs_zero = (divisor == '0);

    // Shift the partial remainder left and bring in the next dividend bit.
    assign w_shift = {r_prem, r_qsh[C_WIDTH-1]};

    subtractor32b u_trial_sub (
        .i_a      (w_shift[C_WIDTH-1:0]),
        .i_b      (r_dvsr),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // Any bit above the 32-bit window means the shifted value already
    // exceeds the divisor; the low 32 bits of the difference are then still
    // exact because the true difference is smaller than the divisor.
    assign w_ge        = (|w_shift[C_WIDTH+1:C_WIDTH]) | ~w_borrow;
    assign w_prem_next = w_ge ? {1'b0, w_diff} : w_shift[C_WIDTH:0];
    assign w_q_next    = {r_qsh[C_WIDTH-2:0], w_ge};
    assign w_last      = (r_cnt == C_CNT_W'(C_ITERS - 1));

    assign w_q_final = neg_if(w_q_next, r_neg_q);
    assign w_r_final = neg_if(w_prem_next[C_WIDTH-1:0], r_neg_r);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_prem      <= '0;
            r_qsh       <= '0;
            r_dvsr      <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_dvs_zero) begin
                            r_state     <= ST_DONE;
                            r_quotient  <= C_DBZ_QUOT;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_prem  <= '0;
                            r_qsh   <= w_dvd_mag;
                            r_dvsr  <= w_dvs_mag;
                            r_cnt   <= '0;
                            r_dbz   <= 1'b0;
                            r_neg_q <= w_signed & (dividend[C_WIDTH-1] ^ divisor[C_WIDTH-1]);
                            r_neg_r <= w_signed & dividend[C_WIDTH-1];
                        end
                    end
                end
                ST_RUN: begin
                    r_prem <= w_prem_next;
                    r_qsh  <= w_q_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_quotient  <= w_q_final;
                        r_remainder <= w_r_final;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign io_oeb      = '0;

endmodule : divider32b
`default_nettype wire

// File: doc/divider32b.md
DIVIDER32B -- requirements
Module: divider32b

Interface
REQ-001 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 32 bits: numerator; captured on the accepted start.
REQ-005 SHALL have port divisor, input, 32 bits: denominator; captured on the accepted start.
REQ-006 SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-008 SHALL have port quotient, output, 32 bits: result quotient.
REQ-009 SHALL have port remainder, output, 32 bits: result remainder.
REQ-010 SHALL have port div_by_zero, output, 1 bit: the last result came from a zero divisor.
REQ-011 SHALL have port io_oeb, output, 33 bits: tied to all zeros.

Function
REQ-012 SHALL use a state machine with states IDLE, RUN and DONE.
REQ-013 SHALL move IDLE->RUN on an edge with start=1 and a nonzero divisor.
- Captures both operands at that edge.
- Clears the partial remainder and the iteration counter.
REQ-014 SHALL perform restoring division in RUN, one quotient bit per edge, MSB first, for exactly 32 edges.
- Shift {partial remainder, next dividend bit} left.
- Trial-subtract the divisor.
- If there is no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
REQ-015 SHALL move RUN->DONE on the 32nd iteration edge.
- done=1 for exactly that one cycle.
- quotient and remainder are valid from that cycle.
REQ-016 SHALL move DONE->IDLE unconditionally on the next edge.
REQ-017 SHALL give a latency from start-accept edge E0 to done=1 of 32 cycles.
- done is high after edge E32; the block is back in IDLE after edge E33.
REQ-018 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next accepted start.
REQ-019 SHALL ignore start when not in IDLE; no error is flagged.
REQ-020 SHALL handle start=1 with divisor=0 by going IDLE->DONE on that edge, skipping RUN.
- quotient=32'hFFFF_FFFF, remainder=dividend, div_by_zero=1.
REQ-021 SHALL clear div_by_zero on any start accepted with a nonzero divisor.
REQ-022 SHALL hold the partial remainder in 33 bits so that no intermediate value overflows.

Reset
REQ-023 SHALL, while wb_rst_i=1 at an edge, force state=IDLE and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-024 SHALL, on reset mid-RUN or in DONE, abandon the operation with no done pulse; start is ignored while wb_rst_i=1.
REQ-025 SHALL keep io_oeb at zero regardless of reset.

Configuration
REQ-026 SHALL provide the macro DIVIDER32B_SIGNED_EN.
- When defined: an extra input signed_op (1 bit) is captured with the operands.
- If signed_op=1, operands are divided as two's-complement magnitudes.
- The quotient is negated when the operand signs differ.
- The remainder takes the sign of the dividend.
- The case -2^31 / -1 yields quotient=32'h8000_0000, remainder=0.
- Divide-by-zero behaviour follows REQ-020.
- When not defined: the port is absent and all operation is unsigned; latency is identical in both builds.

Structure
REQ-027 SHALL place the following in package divider32b_pkg:
- the state encoding;
- the width constant 32;
- the iteration count 32;
- the divide-by-zero quotient constant.
REQ-028 SHALL instantiate one combinational sub-module subtractor32b (a - b, borrow out) for the trial subtraction.

Verification
REQ-029 SHALL cover 100 / 7 unsigned -> quotient=14, remainder=2, done exactly 32 cycles after the accept edge.
REQ-030 SHALL cover 32'hFFFF_FFFF / 1 -> quotient=32'hFFFF_FFFF, remainder=0; and 5 / 9 -> quotient=0, remainder=5.
REQ-031 SHALL cover divisor=0 with dividend=32'h1234 -> done on the next edge, quotient=32'hFFFF_FFFF, remainder=32'h1234, div_by_zero=1.
REQ-032 SHALL cover start pulsed repeatedly during RUN with different operands -> results reflect the first operands only, single done pulse.
REQ-033 SHALL cover wb_rst_i asserted at iteration 10 -> all outputs zero next cycle, no done pulse; a new start then completes normally.
REQ-034 SHALL cover, with DIVIDER32B_SIGNED_EN and signed_op=1:
- -7 / 2 -> quotient=-3, remainder=-1;
- 32'h8000_0000 / -1 -> quotient=32'h8000_0000, remainder=0.
